// File: rtl/bcd_seg_scan.sv
// 3-digit common-anode 7-segment scanner with per-frame snapshot, ghost blanking and sticky overflow.
// Latency: an/seg/dp are registered, one cycle behind the scan state. No backpressure; enable=0 freezes the scan.
// Optional leading-zero blanking of hundreds/tens is built when BCD_SEG_LZB_EN is defined.
module bcd_seg_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ovf_clr,
    input  logic       ceo,
    input  logic [3:0] Q2,
    input  logic [3:0] Q1,
    input  logic [3:0] Q0,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       ovf
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [11:0]   shadow_q, shadow_d;
    logic [2:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    digit;
    logic          blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            // Frame start: latch all digits together so a frame never mixes old and new values.
            if (cnt_q == '0 && idx_q == 2'd0)
                shadow_d = {Q2, Q1, Q0};
        end

        case (idx_q)
            2'd0:    digit = shadow_d[3:0];
            2'd1:    digit = shadow_d[7:4];
            default: digit = shadow_d[11:8];
        endcase

`ifdef BCD_SEG_LZB_EN
        blank = (idx_q == 2'd2 && shadow_d[11:8] == 4'd0) ||
                (idx_q == 2'd1 && shadow_d[11:8] == 4'd0 && shadow_d[7:4] == 4'd0);
`else
        blank = 1'b0;
`endif

        if (!enable || cnt_q < BLANK_LIM)
            an_d = 3'b111;
        else
            an_d = ~(3'b001 << idx_q);

        seg_d = (blank || idx_q == 2'd3) ? 7'h7F : seg7(digit);
        dp_d  = !(idx_q == 2'd2 && ovf_q);

        if (ceo)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= '0;
            an_q     <= 3'b111;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            ovf_q    <= ovf_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with SCAN_DIV=4, BLANK_CYC=1: one frame is 12 cycles,
// each slot one blank cycle followed by three lit cycles.
module tb_bcd_seg_scan;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       ovf_clr;
    logic       ceo;
    logic [3:0] Q2, Q1, Q0;
    logic [2:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ovf;

    int checks = 0;
    int fails  = 0;

    bcd_seg_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .ovf_clr (ovf_clr),
        .ceo     (ceo),
        .Q2      (Q2),
        .Q1      (Q1),
        .Q0      (Q0),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full frame; s0/s1/s2 are the hand-computed seg codes for units/tens/hundreds.
    // chg: after this tick set Q0=nq0. frz: after this tick hold enable low for two cycles.
    task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic dp2_low, input int chg, input logic [3:0] nq0,
                             input int frz);
        logic [6:0] sv [3];
        sv[0] = s0; sv[1] = s1; sv[2] = s2;
        for (int i = 1; i <= 12; i++) begin
            int slot;
            int c;
            logic [2:0] ea;
            logic       edp;
            tick();
            slot = (i - 1) / 4;
            c    = (i - 1) % 4;
            ea   = (c == 0) ? 3'b111 : ~(3'b001 << slot);
            edp  = (dp2_low && slot == 2) ? 1'b0 : 1'b1;
            chk("an",  {29'd0, an},  {29'd0, ea});
            chk("seg", {25'd0, seg}, {25'd0, sv[slot]});
            chk("dp",  {31'd0, dp},  {31'd0, edp});
            if (i == chg) Q0 = nq0;
            if (i == frz) begin
                enable = 1'b0;
                tick();
                chk("an_frz1", {29'd0, an}, 32'h7);
                tick();
                chk("an_frz2", {29'd0, an}, 32'h7);
                enable = 1'b1;
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; ovf_clr = 1'b0; ceo = 1'b0;
        Q2 = 4'd1; Q1 = 4'd2; Q0 = 4'd3;
        #1 reset = 1'b0;
        #1;
        chk("rst_an",  {29'd0, an},  32'h7);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp",  {31'd0, dp},  32'h1);
        chk("rst_ovf", {31'd0, ovf}, 32'h0);
        tick(); tick();
        reset = 1'b1; enable = 1'b1;

        // 123: lit after two cycles, then 30 / 24 / 79 with one blank cycle per slot.
        run_frame(7'h30, 7'h24, 7'h79, 1'b0, -1, 4'd0, -1);
        // Q0 changes during the tens slot; this frame still holds the snapshot.
        run_frame(7'h30, 7'h24, 7'h79, 1'b0, 5, 4'd5, -1);
        run_frame(7'h12, 7'h24, 7'h79, 1'b0, -1, 4'd0, -1);

        Q2 = 4'd0; Q1 = 4'd0; Q0 = 4'd7;
`ifdef BCD_SEG_LZB_EN
        run_frame(7'h78, 7'h7F, 7'h7F, 1'b0, -1, 4'd0, -1);
`else
        run_frame(7'h78, 7'h40, 7'h40, 1'b0, -1, 4'd0, -1);
`endif

        // Overflow set while the scan is frozen; ovf does not depend on enable.
        enable = 1'b0; ceo = 1'b1;
        tick();
        chk("ovf_set",  {31'd0, ovf}, 32'h1);
        chk("an_dark",  {29'd0, an},  32'h7);
        ceo = 1'b0;
        tick();
        chk("ovf_hold", {31'd0, ovf}, 32'h1);
        enable = 1'b1;
        Q2 = 4'd1; Q1 = 4'hC; Q0 = 4'd3;
        run_frame(7'h30, 7'h3F, 7'h79, 1'b1, -1, 4'd0, -1);

        enable = 1'b0; ovf_clr = 1'b1;
        tick();
        chk("ovf_clr",  {31'd0, ovf}, 32'h0);
        ceo = 1'b1;
        tick();
        chk("ovf_both", {31'd0, ovf}, 32'h1);
        ceo = 1'b0;
        tick();
        chk("ovf_clr2", {31'd0, ovf}, 32'h0);
        ovf_clr = 1'b0; enable = 1'b1;
        run_frame(7'h30, 7'h3F, 7'h79, 1'b0, -1, 4'd0, -1);

        // Freeze in the middle of the tens slot; scan resumes where it stopped.
        run_frame(7'h30, 7'h3F, 7'h79, 1'b0, -1, 4'd0, 6);

        // Asynchronous reset mid-slot with ovf set.
        ceo = 1'b1;
        tick();
        ceo = 1'b0;
        tick(); tick();
        chk("pre_rst_an",  {29'd0, an},  32'h6);
        chk("pre_rst_ovf", {31'd0, ovf}, 32'h1);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_an",  {29'd0, an},  32'h7);
        chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
        chk("mid_rst_dp",  {31'd0, dp},  32'h1);
        chk("mid_rst_ovf", {31'd0, ovf}, 32'h0);
        tick();
        reset = 1'b1;
        Q0 = 4'd9;
        tick();
        chk("rel_an1",  {29'd0, an},  32'h7);
        tick();
        chk("rel_an2",  {29'd0, an},  32'h6);
        chk("rel_seg2", {25'd0, seg}, 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Display stage downstream of the 3-digit BCD counter; consumes its three digit outputs and its carry-out.
- Time-multiplexes the digits onto one common-anode 7-segment bus with per-digit anode select.
- Provides tear-free snapshot per scan frame, inter-digit ghost blanking, leading-zero suppression and a sticky overflow indicator.

Parameters:
SCAN_DIV, 50000, clock cycles each digit is selected (>= 2)
BLANK_CYC, 500, cycles at start of each digit slot with all anodes off (< SCAN_DIV)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  scan enable; low = display dark, scan frozen
ovf_clr  input  1  synchronous clear of sticky overflow flag
ceo  input  1  carry-out of counter (count wrapped past 999)
Q2  input  4  hundreds BCD digit
Q1  input  4  tens BCD digit
Q0  input  4  units BCD digit
an  output  3  anode select, active-low one-hot (an[0]=units)
seg  output  7  segments gfedcba, active-low
dp  output  1  decimal point, active-low
ovf  output  1  sticky overflow flag, active-high

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, reset).
- Reset (reset=0, immediate): an=3'b111, seg=7'h7F, dp=1, ovf=0; internal cnt=0, idx=0, shadow digits=0.
- Prescaler cnt: counts 0..SCAN_DIV-1 while enable=1; at SCAN_DIV-1 wraps to 0 and idx advances 0->1->2->0. enable=0 holds cnt and idx.
- Snapshot: shadow <= {Q2,Q1,Q0} on the cycle enable=1 && cnt==0 && idx==0 (frame start). Digits are never read mid-frame; mid-frame input changes appear next frame.
- Outputs registered: an/seg/dp reflect cnt/idx/shadow of the previous cycle (1-cycle latency).
- an: all 1 when enable=0 or cnt<BLANK_CYC; otherwise bit idx low, others high.
- seg decode (active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex). Nibble >9 shows dash 7'h3F.
- Blanked digit: seg=7'h7F while that digit is selected (anode still driven).
- dp: low only when idx==2 and ovf=1; otherwise high.
- ovf: set when ceo=1 at a clock edge; cleared when ovf_clr=1 and ceo=0. If both are 1 in the same cycle, set wins. Independent of enable.
- No state machine beyond the idx ring; idx value 3 is unreachable and recovers to 0 on next advance.
- Reset mid-frame: all outputs dark immediately; the first frame after release takes a fresh snapshot at cnt=0, idx=0.

Optional Feature:
- Macro BCD_SEG_LZB_EN.
- Defined: leading-zero blanking. Hundreds digit is blank if shadow Q2==0. Tens digit is blank if Q2==0 and Q1==0. Units digit is never blanked, so 000 shows "0" and 007 shows "7".
- Undefined: all three digits are always decoded, so 007 shows "007". The dp/ovf rule is unchanged.

Test Plan (SCAN_DIV=4, BLANK_CYC=1):
- Reset asserted mid-scan -> an=111, seg=7F, dp=1, ovf=0 same cycle, no clock needed. Release, enable=1 -> first lit anode an=110 two cycles after release (blank slot plus register latency).
- Inputs Q2=1 Q1=2 Q0=3, enable=1 -> frame sequence: an=110/seg=30, an=101/seg=24, an=011/seg=79, each lit 3 cycles, separated by 1 blank cycle with an=111.
- Change Q0 from 3 to 5 while idx=1 -> current frame still shows units 30; next frame shows 12.
- Inputs 0,0,7 with BCD_SEG_LZB_EN defined -> units seg=78, tens/hundreds seg=7F. Without the macro -> seg=40, 40, 78.
- Pulse ceo=1 for one cycle -> ovf=1 next cycle; dp=0 during the hundreds slot only. ovf_clr=1 with ceo=0 -> ovf=0, dp=1. ceo and ovf_clr high together -> ovf stays 1.
- Q1=4'hC -> dash 3F in tens slot. enable=0 mid-slot -> an=111 next cycle, cnt and idx frozen; scan resumes from the same slot when enable returns to 1.
